// File: rtl/asic_freq_meter.sv
// asic_freq_meter: gated edge counter with free-running total, 9-digit
// multiplexed 7-segment display and ASCII-hex UART report of each window.
module asic_freq_meter #(
  parameter int unsigned DEF_BAUD_DIV = 434,
  parameter int unsigned DEF_PERIOD   = 1000000,
  parameter int unsigned SCAN_BITS    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic [31:0] value,
  input  logic        strobe,
  input  logic        samplee,
  output logic [31:0] o,
  output logic [31:0] oc,
  output logic        tx,
  output logic [8:0]  col_drvs,
  output logic [7:0]  seg_drvs
);

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_st_e;

  localparam logic [35:0] BCD_MAX = 36'h999999999;

  // Ripple-carry increment of a 9-digit packed BCD value, holding at all nines.
  function automatic logic [35:0] bcd_inc(input logic [35:0] v);
    logic [35:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != BCD_MAX) begin
      for (int i = 0; i < 9; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Segment pattern a..g for a hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Character c of the report line: 8 uppercase hex digits MSB first, CR, LF.
  function automatic logic [7:0] char_of(input logic [31:0] w, input logic [3:0] c);
    logic [2:0] idx;
    logic [3:0] nib;
    logic [7:0] ch;
    idx = 3'd7 - c[2:0];
    nib = w[{idx, 2'b00} +: 4];
    if (c == 4'd8) begin
      ch = 8'h0D;
    end else if (c == 4'd9) begin
      ch = 8'h0A;
    end else if (nib < 4'd10) begin
      ch = 8'h30 + {4'd0, nib};
    end else begin
      ch = 8'h37 + {4'd0, nib};
    end
    return ch;
  endfunction

  // Configuration registers
  logic [15:0] baud_q;
  logic [31:0] period_q;
  logic        mode_q;
  logic [35:0] digits_q;
  logic [8:0]  dp_q;
  logic        period_wr;

  assign period_wr = strobe && (addr == 4'd1);

  // Register write port with clamping of baud divider and window length.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q   <= 16'(DEF_BAUD_DIV);
      period_q <= 32'(DEF_PERIOD);
      mode_q   <= 1'b0;
      digits_q <= 36'd0;
      dp_q     <= 9'd0;
    end else if (strobe) begin
      case (addr)
        4'd0: baud_q   <= (value[15:0] < 16'd4) ? 16'd4 : value[15:0];
        4'd1: period_q <= (value == 32'd0) ? 32'd1 : value;
        4'd2: mode_q   <= value[0];
        4'd3: digits_q[31:0]  <= value;
        4'd4: digits_q[35:32] <= value[3:0];
        4'd5: dp_q     <= value[8:0];
        default: ;
      endcase
    end
  end

  // Input synchronizer and rising-edge detector
  logic [2:0] sync_q;
  logic       pulse;

  assign pulse = sync_q[1] & ~sync_q[2];

  // Two flops for metastability, third flop to detect the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], samplee};
    end
  end

  // Gate timer, window counters and latched results
  logic [31:0] timer_q, timer_d;
  logic [31:0] win_q, win_d, win_inc;
  logic [35:0] bcd_q, bcd_d, bcd_next;
  logic [35:0] disp_q, disp_d;
  logic [31:0] o_q, o_d;
  logic [31:0] oc_q;
  logic        win_end;
  logic        uart_go;

  assign win_end  = (timer_q == period_q - 32'd1);
  assign win_inc  = win_q + {31'd0, pulse};
  assign bcd_next = pulse ? bcd_inc(bcd_q) : bcd_q;

  // Window bookkeeping: a pulse on the closing clock still belongs to that window.
  always_comb begin
    timer_d = timer_q + 32'd1;
    win_d   = win_inc;
    bcd_d   = bcd_next;
    o_d     = o_q;
    disp_d  = disp_q;
    uart_go = 1'b0;
    if (period_wr) begin
      timer_d = 32'd0;
      win_d   = 32'd0;
      bcd_d   = 36'd0;
    end else if (win_end) begin
      o_d     = win_inc;
      disp_d  = bcd_next;
      timer_d = 32'd0;
      win_d   = 32'd0;
      bcd_d   = 36'd0;
      uart_go = 1'b1;
    end
  end

  // Gate and count registers; oc is only ever cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= 32'd0;
      win_q   <= 32'd0;
      bcd_q   <= 36'd0;
      disp_q  <= 36'd0;
      o_q     <= 32'd0;
      oc_q    <= 32'd0;
    end else begin
      timer_q <= timer_d;
      win_q   <= win_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      o_q     <= o_d;
      oc_q    <= oc_q + {31'd0, pulse};
    end
  end

  assign o  = o_q;
  assign oc = oc_q;

  // Display scan
  logic [SCAN_BITS-1:0] scan_q;
  logic [3:0]           k_q;
  logic [3:0]           nib;

  // Each digit is lit for 2**SCAN_BITS clocks, digits 0..8 in turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      k_q    <= 4'd0;
    end else begin
      scan_q <= scan_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
      if (&scan_q) begin
        k_q <= (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
      end
    end
  end

  assign nib      = mode_q ? digits_q[{k_q, 2'b00} +: 4] : disp_q[{k_q, 2'b00} +: 4];
  assign col_drvs = 9'd1 << k_q;
  assign seg_drvs = {dp_q[k_q], glyph(nib)};

  // UART transmitter
  uart_st_e    ust_q, ust_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d, nxt_bit;
  logic [3:0]  chr_q, chr_d;
  logic [31:0] word_q, word_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic [7:0]  cur_char;

  assign bit_end  = (cnt_q == div_q - 16'd1);
  assign cur_char = char_of(word_q, chr_q);
  assign nxt_bit  = bit_q + 3'd1;

  // Frame sequencing; the divider is reloaded at the start of every character.
  always_comb begin
    ust_d  = ust_q;
    cnt_d  = cnt_q + 16'd1;
    div_d  = div_q;
    bit_d  = bit_q;
    chr_d  = chr_q;
    word_d = word_q;
    tx_d   = tx_q;
    case (ust_q)
      U_IDLE: begin
        cnt_d = 16'd0;
        tx_d  = 1'b1;
        if (uart_go) begin
          ust_d  = U_START;
          tx_d   = 1'b0;
          chr_d  = 4'd0;
          word_d = o_d;
          div_d  = baud_q;
        end
      end
      U_START: begin
        if (bit_end) begin
          ust_d = U_DATA;
          cnt_d = 16'd0;
          bit_d = 3'd0;
          tx_d  = cur_char[0];
        end
      end
      U_DATA: begin
        if (bit_end) begin
          cnt_d = 16'd0;
          if (bit_q == 3'd7) begin
            ust_d = U_STOP;
            tx_d  = 1'b1;
          end else begin
            bit_d = nxt_bit;
            tx_d  = cur_char[nxt_bit];
          end
        end
      end
      U_STOP: begin
        if (bit_end) begin
          cnt_d = 16'd0;
          if (chr_q == 4'd9) begin
            ust_d = U_IDLE;
            tx_d  = 1'b1;
          end else begin
            ust_d = U_START;
            chr_d = chr_q + 4'd1;
            div_d = baud_q;
            tx_d  = 1'b0;
          end
        end
      end
      default: begin
        ust_d = U_IDLE;
        tx_d  = 1'b1;
      end
    endcase
  end

  // UART control state; reset aborts any frame and drives the line idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ust_q <= U_IDLE;
      cnt_q <= 16'd0;
      div_q <= 16'(DEF_BAUD_DIV);
      bit_q <= 3'd0;
      chr_q <= 4'd0;
      tx_q  <= 1'b1;
    end else begin
      ust_q <= ust_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      bit_q <= bit_d;
      chr_q <= chr_d;
      tx_q  <= tx_d;
    end
  end

  // Snapshot of the reported count, only meaningful while a frame is active.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_asic_freq_meter.sv
// Directed testbench for asic_freq_meter.
module tb_asic_freq_meter;

  logic        clk;
  logic        rst;
  logic [3:0]  addr;
  logic [31:0] value;
  logic        strobe;
  logic        samplee;
  logic [31:0] o;
  logic [31:0] oc;
  logic        tx;
  logic [8:0]  col_drvs;
  logic [7:0]  seg_drvs;

  int checks;
  int failures;
  int edges;

  localparam logic [7:0] GLYPH [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  localparam logic [7:0] UART_EXP [10] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
                                           8'h31, 8'h41, 8'h0D, 8'h0A};

  asic_freq_meter #(
    .DEF_BAUD_DIV(434),
    .DEF_PERIOD  (1000000),
    .SCAN_BITS   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .value   (value),
    .strobe  (strobe),
    .samplee (samplee),
    .o       (o),
    .oc      (oc),
    .tx      (tx),
    .col_drvs(col_drvs),
    .seg_drvs(seg_drvs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    edges = 0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] v);
    addr   = a;
    value  = v;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic toggle_run(input int ncyc, input int half);
    int c;
    c = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      c++;
      if (c == half) begin
        c = 0;
        samplee = ~samplee;
        if (samplee) edges++;
      end
    end
  endtask

  task automatic wait_col(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (col_drvs == (9'd1 << k)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    samplee = 1'b0;
    do_reset();
    checks++; if (o !== 32'd0) begin failures++; $display("FAIL reset_o got=%0h exp=0", o); end
    checks++; if (oc !== 32'd0) begin failures++; $display("FAIL reset_oc got=%0h exp=0", oc); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (col_drvs !== 9'h001) begin failures++; $display("FAIL reset_col got=%h exp=001", col_drvs); end
    checks++; if (seg_drvs !== 8'h3F) begin failures++; $display("FAIL reset_seg got=%h exp=3f", seg_drvs); end
  endtask

  task automatic test_periodic();
    bit ok;
    samplee = 1'b0;
    do_reset();
    write_reg(4'd1, 32'd100);
    toggle_run(450, 5);
    write_reg(4'd1, 32'd1000000);
    repeat (5) tick();
    checks++; if (o !== 32'd10) begin failures++; $display("FAIL periodic_o got=%0d exp=10", o); end
    checks++; if (oc !== 32'(edges)) begin failures++; $display("FAIL periodic_oc got=%0d exp=%0d", oc, edges); end
    wait_col(0, ok);
    checks++; if (!ok || seg_drvs !== 8'h3F) begin failures++; $display("FAIL bcd_digit0 got=%h exp=3f", seg_drvs); end
    wait_col(1, ok);
    checks++; if (!ok || seg_drvs !== 8'h06) begin failures++; $display("FAIL bcd_digit1 got=%h exp=06", seg_drvs); end
    wait_col(2, ok);
    checks++; if (!ok || seg_drvs !== 8'h3F) begin failures++; $display("FAIL bcd_digit2 got=%h exp=3f", seg_drvs); end
  endtask

  task automatic test_constant();
    logic [31:0] oc0;
    write_reg(4'd1, 32'd100);
    oc0 = oc;
    repeat (1000) tick();
    checks++; if (o !== 32'd0) begin failures++; $display("FAIL const_o got=%0d exp=0", o); end
    checks++; if (oc !== oc0) begin failures++; $display("FAIL const_oc got=%0d exp=%0d", oc, oc0); end
    samplee = 1'b0;
    repeat (5) tick();
    oc0 = oc;
    samplee = 1'b1;
    repeat (2) tick();
    checks++; if (oc !== oc0) begin failures++; $display("FAIL edge_early got=%0d exp=%0d", oc, oc0); end
    tick();
    checks++; if (oc !== oc0 + 32'd1) begin failures++; $display("FAIL edge_latency got=%0d exp=%0d", oc, oc0 + 32'd1); end
  endtask

  task automatic test_period_one();
    samplee = 1'b0;
    repeat (5) tick();
    write_reg(4'd1, 32'd0);
    samplee = 1'b1;
    repeat (2) tick();
    checks++; if (o !== 32'd0) begin failures++; $display("FAIL p1_before got=%0d exp=0", o); end
    tick();
    checks++; if (o !== 32'd1) begin failures++; $display("FAIL p1_latch got=%0d exp=1", o); end
    tick();
    checks++; if (o !== 32'd0) begin failures++; $display("FAIL p1_next got=%0d exp=0", o); end
  endtask

  task automatic test_uart();
    bit          found;
    logic        cap [400];
    logic [39:0] act;
    logic [39:0] expv;
    samplee = 1'b0;
    do_reset();
    write_reg(4'd0, 32'd2);
    write_reg(4'd1, 32'd200);
    for (int i = 0; i < 26; i++) begin
      samplee = 1'b1;
      repeat (3) tick();
      samplee = 1'b0;
      repeat (3) tick();
    end
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL uart_start got=no_start_bit exp=start_bit_within_400");
    end else begin
      checks++; if (o !== 32'h1A) begin failures++; $display("FAIL uart_o got=%h exp=1a", o); end
      checks++; if (oc !== 32'd26) begin failures++; $display("FAIL uart_oc got=%0d exp=26", oc); end
      cap[0] = tx;
      for (int j = 1; j < 400; j++) begin
        tick();
        cap[j] = tx;
      end
      for (int c = 0; c < 10; c++) begin
        for (int j = 0; j < 40; j++) begin
          act[j] = cap[c*40 + j];
          if (j / 4 == 0) expv[j] = 1'b0;
          else if (j / 4 == 9) expv[j] = 1'b1;
          else expv[j] = UART_EXP[c][j/4 - 1];
        end
        checks++;
        if (act !== expv) begin
          failures++;
          $display("FAIL uart_char%0d got=%h exp=%h", c, act, expv);
        end
      end
    end
  endtask

  task automatic test_display();
    bit         ok;
    logic [7:0] exp_seg;
    write_reg(4'd2, 32'd1);
    write_reg(4'd3, 32'h76543210);
    write_reg(4'd4, 32'd8);
    write_reg(4'd5, 32'h001);
    for (int k = 0; k < 9; k++) begin
      wait_col(k, ok);
      exp_seg = GLYPH[k] | ((k == 0) ? 8'h80 : 8'h00);
      checks++;
      if (!ok || seg_drvs !== exp_seg) begin
        failures++;
        $display("FAIL disp_digit%0d col=%h got=%h exp=%h", k, col_drvs, seg_drvs, exp_seg);
      end
    end
    write_reg(4'd3, 32'hFEDCBA98);
    write_reg(4'd5, 32'h000);
    for (int k = 0; k < 8; k++) begin
      wait_col(k, ok);
      checks++;
      if (!ok || seg_drvs !== GLYPH[k + 8]) begin
        failures++;
        $display("FAIL hex_digit%0d col=%h got=%h exp=%h", k, col_drvs, seg_drvs, GLYPH[k + 8]);
      end
    end
  endtask

  task automatic test_reset_mid();
    samplee = 1'b0;
    do_reset();
    write_reg(4'd1, 32'd50);
    toggle_run(120, 5);
    checks++; if (o !== 32'd5) begin failures++; $display("FAIL mid_o_pre got=%0d exp=5", o); end
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_tx_pre got=%b exp=0", tx); end
    rst = 1'b1;
    tick();
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_tx got=%b exp=1", tx); end
    checks++; if (o !== 32'd0) begin failures++; $display("FAIL mid_o got=%0d exp=0", o); end
    checks++; if (oc !== 32'd0) begin failures++; $display("FAIL mid_oc got=%0d exp=0", oc); end
    checks++; if (col_drvs !== 9'h001) begin failures++; $display("FAIL mid_col got=%h exp=001", col_drvs); end
    rst = 1'b0;
    tick();
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_tx_after got=%b exp=1", tx); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    edges    = 0;
    rst      = 1'b1;
    addr     = 4'd0;
    value    = 32'd0;
    strobe   = 1'b0;
    samplee  = 1'b0;
    test_reset();
    test_periodic();
    test_constant();
    test_period_one();
    test_uart();
    test_display();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
